cla_adder_4bit: RTL and testbench



---
 rtl/cla_pkg.sv | 10 +
 rtl/cla_logic.sv | 48 ++++
 rtl/cla_adder_4bit.sv | 78 +++++++
 tb/tb_cla_adder_4bit.sv | 111 +++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the 4-bit carry-lookahead adder.
// Optional input register stage is selected with CLA_ADDER_INREG_EN.
package cla_pkg;
    localparam int CLA_W = 4;

    typedef logic [CLA_W-1:0] cla_word_t;

    localparam cla_word_t CLA_S_RST = '0;
    localparam logic      CLA_C_RST = 1'b0;
endpackage

// File: rtl/cla_logic.sv
// Combinational two-level lookahead core: flat sum-of-products carries, no ripple.
// gg/gp are the group generate/propagate terms for cascading into a wider CLA.
module cla_logic
    import cla_pkg::*;
(
    input  cla_word_t a,
    input  cla_word_t b,
    input  logic      c0,
    output cla_word_t s_comb,
    output logic      c4_comb,
    output logic      gg,
    output logic      gp
);
    logic [CLA_W-1:0] w_g;
    logic [CLA_W-1:0] w_p;
    logic [CLA_W:0]   w_c;

    for (genvar i = 0; i < CLA_W; i++) begin : g_gp
        assign w_g[i] = a[i] & b[i];
        assign w_p[i] = a[i] ^ b[i];
    end

    // Each carry is expanded directly from g/p/c0 so every carry is two gate levels deep.
    assign w_c[0] = c0;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & c0);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & c0);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c0);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c0);

    assign gg = w_g[3]
              | (w_p[3] & w_g[2])
              | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign gp = &w_p;

    assign s_comb  = w_p ^ w_c[CLA_W-1:0];
    assign c4_comb = w_c[CLA_W];
endmodule

// File: rtl/cla_adder_4bit.sv
// Registered 4-bit CLA: {c4,s} = a + b + c0, one cycle latency by default.
// Define CLA_ADDER_INREG_EN to add an input register stage (two cycle latency).
module cla_adder_4bit
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             c0,
    output logic [CLA_W-1:0] s,
    output logic             c4
);
    cla_word_t w_a;
    cla_word_t w_b;
    logic      w_c0;
    cla_word_t w_s;
    logic      w_c4;
    logic      w_gg;
    logic      w_gp;
    cla_word_t r_s;
    logic      r_c4;

`ifdef CLA_ADDER_INREG_EN
    cla_word_t r_a;
    cla_word_t r_b;
    logic      r_c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c0 <= 1'b0;
        end else begin
            r_a  <= a;
            r_b  <= b;
            r_c0 <= c0;
        end
    end

    assign w_a  = r_a;
    assign w_b  = r_b;
    assign w_c0 = r_c0;
`else
    assign w_a  = a;
    assign w_b  = b;
    assign w_c0 = c0;
`endif

    cla_logic u_logic (
        .a       (w_a),
        .b       (w_b),
        .c0      (w_c0),
        .s_comb  (w_s),
        .c4_comb (w_c4),
        .gg      (w_gg),
        .gp      (w_gp)
    );

    // Group terms must reproduce the flat carry-out; catches a broken cascade interface.
    always_comb begin
        if (!$isunknown({w_a, w_b, w_c0}))
            assert (w_c4 == (w_gg | (w_gp & w_c0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= CLA_S_RST;
            r_c4 <= CLA_C_RST;
        end else begin
            r_s  <= w_s;
            r_c4 <= w_c4;
        end
    end

    assign s  = r_s;
    assign c4 = r_c4;
endmodule

// File: tb/tb_cla_adder_4bit.sv
// Self-checking bench for cla_adder_4bit against plain a+b+c0 arithmetic.
// Latency expectation follows CLA_ADDER_INREG_EN.
module tb_cla_adder_4bit;
`ifdef CLA_ADDER_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic [3:0] s;
    logic       c4;

    int n_chk  = 0;
    int n_pass = 0;
    logic [4:0] exp_q[$];

    cla_adder_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c0    (c0),
        .s     (s),
        .c4    (c4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {c4,s}=%b expected %b", tag, got, exp);
    endtask

    function automatic logic [4:0] ref_sum(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int sum;
        sum = int'(ta) + int'(tb) + int'(tc);
        return sum[4:0];
    endfunction

    // Any input stage is cleared by reset, so it holds a 0 result in flight.
    task automatic flush_model();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(5'd0);
    endtask

    // Apply one input vector at a negedge, clock it, compare at the next negedge.
    task automatic cyc(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input string tag);
        a = ta; b = tb; c0 = tc;
        @(posedge clk);
        exp_q.push_back(ref_sum(ta, tb, tc));
        @(negedge clk);
        if (exp_q.size() >= LAT) chk(tag, {c4, s}, exp_q[exp_q.size() - LAT]);
    endtask

    initial begin
        logic [4:0] held;
        rst_n = 1'b0;
        a = 'x; b = 'x; c0 = 1'bx;
        #2;
        chk("rst_x_inputs", {c4, s}, 5'd0);
        @(negedge clk);
        a = 4'd0; b = 4'd0; c0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {c4, s}, 5'd0);
        end
        rst_n = 1'b1;
        flush_model();
        for (int i = 0; i < LAT; i++) cyc(4'd0, 4'd0, 1'b1, "rst_release");
        chk("rst_release_val", {c4, s}, 5'b00001);

        cyc(4'b0001, 4'b1000, 1'b0, "dir_0001_1000");
        cyc(4'b0110, 4'b0101, 1'b1, "dir_0110_0101_c");
        cyc(4'b1111, 4'b1111, 1'b0, "dir_1111_1111");
        cyc(4'b1010, 4'b0101, 1'b1, "dir_full_prop");
        cyc(4'b0011, 4'b1111, 1'b1, "dir_0011_1111_c");
        for (int i = 1; i < LAT; i++) cyc(4'b0011, 4'b1111, 1'b1, "dir_0011_1111_c");
        chk("dir_0011_1111_c_val", {c4, s}, 5'b10011);

        // Inputs moving between edges must not reach the outputs.
        held = {c4, s};
        #2 a = 4'b0101; b = 4'b0010; c0 = 1'b0;
        #1 chk("mid_cycle_hold", {c4, s}, held);

        // Asynchronous reset pulse between edges.
        rst_n = 1'b0;
        #1 chk("async_rst", {c4, s}, 5'd0);
        rst_n = 1'b1;
        flush_model();
        for (int i = 0; i < LAT; i++) cyc(4'b0011, 4'b1111, 1'b1, "post_rst_reload");
        chk("post_rst_reload_val", {c4, s}, 5'b10011);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            cyc(v[3:0], v[7:4], v[8], "sweep");
        end

        for (int i = 0; i < 200; i++)
            cyc(4'($urandom), 4'($urandom), 1'($urandom), "random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
